// File: rtl/qblock_item_roulette_if.sv
// Handshake bundle between the Q-block handler/controls and the item roulette.
// The master drives collisions, use buttons and clear; the slave returns slot state and use pulses.
interface qblock_item_roulette_if #(
    parameter int unsigned ITEM_WIDTH = 2
);
    logic                  clear;
    logic                  car1_collision;
    logic                  car2_collision;
    logic                  car1_use;
    logic                  car2_use;
    logic [ITEM_WIDTH-1:0] car1_item;
    logic [ITEM_WIDTH-1:0] car2_item;
    logic                  car1_spinning;
    logic                  car2_spinning;
    logic                  car1_use_pulse;
    logic                  car2_use_pulse;
    logic [ITEM_WIDTH-1:0] car1_use_item;
    logic [ITEM_WIDTH-1:0] car2_use_item;

    modport master (
        output clear, car1_collision, car2_collision, car1_use, car2_use,
        input  car1_item, car2_item, car1_spinning, car2_spinning,
        input  car1_use_pulse, car2_use_pulse, car1_use_item, car2_use_item
    );

    modport slave (
        input  clear, car1_collision, car2_collision, car1_use, car2_use,
        output car1_item, car2_item, car1_spinning, car2_spinning,
        output car1_use_pulse, car2_use_pulse, car1_use_item, car2_use_item
    );
endinterface

// File: rtl/qblock_item_roulette.sv
// Per-car Q-block item roulette: a collision rise spins a roulette for SPIN_FRAMES frames, then an
// LFSR-chosen item is held until a use rise spends it as a one-cycle pulse.
module qblock_item_roulette #(
    parameter int unsigned NUM_ITEMS   = 3,
    parameter int unsigned ITEM_WIDTH  = 2,
    parameter int unsigned SPIN_FRAMES = 120,
    parameter int unsigned SPIN_STEP   = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic                   render_clk,
    input logic                   rst_n,
    qblock_item_roulette_if.slave bus
);
    localparam int unsigned CntW  = (SPIN_FRAMES > 1) ? $clog2(SPIN_FRAMES) : 1;
    localparam int unsigned StepW = (SPIN_STEP > 1) ? $clog2(SPIN_STEP) : 1;

    typedef enum logic [1:0] {StEmpty, StSpin, StHold} state_e;

    state_e                state_q    [2];
    state_e                state_d    [2];
    logic [CntW-1:0]       spin_cnt_q [2];
    logic [CntW-1:0]       spin_cnt_d [2];
    logic [StepW-1:0]      step_cnt_q [2];
    logic [StepW-1:0]      step_cnt_d [2];
    logic [ITEM_WIDTH-1:0] item_q     [2];
    logic [ITEM_WIDTH-1:0] item_d     [2];
    logic [ITEM_WIDTH-1:0] use_item_q [2];
    logic [ITEM_WIDTH-1:0] use_item_d [2];
    logic [ITEM_WIDTH-1:0] roll       [2];
    logic [1:0]            pulse_q, pulse_d;
    logic [1:0]            coll, use_btn, coll_prev_q, use_prev_q, coll_rise, use_rise;
    logic [15:0]           lfsr_q;

    assign coll      = {bus.car2_collision, bus.car1_collision};
    assign use_btn   = {bus.car2_use, bus.car1_use};
    assign coll_rise = coll & ~coll_prev_q;
    assign use_rise  = use_btn & ~use_prev_q;

    // Each car draws from its own LFSR byte so simultaneous hits roll independently
    assign roll[0] = ITEM_WIDTH'(({1'b0, lfsr_q[7:0]} % 9'(NUM_ITEMS)) + 9'd1);
    assign roll[1] = ITEM_WIDTH'(({1'b0, lfsr_q[15:8]} % 9'(NUM_ITEMS)) + 9'd1);

    always_ff @(posedge render_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= LFSR_SEED;
            coll_prev_q <= '0;
            use_prev_q  <= '0;
            pulse_q     <= '0;
            for (int c = 0; c < 2; c++) begin
                state_q[c]    <= StEmpty;
                spin_cnt_q[c] <= '0;
                step_cnt_q[c] <= '0;
                item_q[c]     <= '0;
                use_item_q[c] <= '0;
            end
        end else begin
            lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            coll_prev_q <= coll;
            use_prev_q  <= use_btn;
            pulse_q     <= pulse_d;
            for (int c = 0; c < 2; c++) begin
                state_q[c]    <= state_d[c];
                spin_cnt_q[c] <= spin_cnt_d[c];
                step_cnt_q[c] <= step_cnt_d[c];
                item_q[c]     <= item_d[c];
                use_item_q[c] <= use_item_d[c];
            end
        end
    end

    always_comb begin
        pulse_d = '0;
        for (int c = 0; c < 2; c++) begin
            state_d[c]    = state_q[c];
            spin_cnt_d[c] = spin_cnt_q[c];
            step_cnt_d[c] = step_cnt_q[c];
            item_d[c]     = item_q[c];
            use_item_d[c] = '0;
            if (bus.clear) begin
                state_d[c]    = StEmpty;
                spin_cnt_d[c] = '0;
                step_cnt_d[c] = '0;
                item_d[c]     = '0;
            end else begin
                unique case (state_q[c])
                    StEmpty: begin
                        if (coll_rise[c]) begin
                            state_d[c]    = StSpin;
                            spin_cnt_d[c] = CntW'(SPIN_FRAMES - 1);
                            step_cnt_d[c] = '0;
                            item_d[c]     = ITEM_WIDTH'(1);
                        end
                    end
                    StSpin: begin
                        if (spin_cnt_q[c] == '0) begin
                            state_d[c] = StHold;
                            item_d[c]  = roll[c];
                        end else begin
                            spin_cnt_d[c] = spin_cnt_q[c] - CntW'(1);
                            if (step_cnt_q[c] == StepW'(SPIN_STEP - 1)) begin
                                step_cnt_d[c] = '0;
                                item_d[c]     = (item_q[c] == ITEM_WIDTH'(NUM_ITEMS)) ?
                                                ITEM_WIDTH'(1) : item_q[c] + ITEM_WIDTH'(1);
                            end else begin
                                step_cnt_d[c] = step_cnt_q[c] + StepW'(1);
                            end
                        end
                    end
                    StHold: begin
                        // A same-cycle collision rise is dropped: the slot only refills from empty
                        if (use_rise[c]) begin
                            state_d[c]    = StEmpty;
                            pulse_d[c]    = 1'b1;
                            use_item_d[c] = item_q[c];
                            item_d[c]     = '0;
                        end
                    end
                    default: state_d[c] = StEmpty;
                endcase
            end
        end
    end

    assign bus.car1_item      = item_q[0];
    assign bus.car2_item      = item_q[1];
    assign bus.car1_spinning  = (state_q[0] == StSpin);
    assign bus.car2_spinning  = (state_q[1] == StSpin);
    assign bus.car1_use_pulse = pulse_q[0];
    assign bus.car2_use_pulse = pulse_q[1];
    assign bus.car1_use_item  = use_item_q[0];
    assign bus.car2_use_item  = use_item_q[1];
endmodule
